// File: rtl/spimemio_pkg.sv
// Shared definitions for the spimemio read cache: line geometry and controller states.
package spimemio_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_t;

endpackage

// File: rtl/spimemio_cache.sv
// Direct-mapped, read-only instruction/data cache in front of the spimemio flash port.
// Misses are filled as sequential 4-word bursts to keep the flash in continuous-read mode.
module spimemio_cache
  import spimemio_pkg::*;
#(
  parameter  int LINES    = 16,
  localparam int IDX_BITS = $clog2(LINES),
  localparam int TAG_BITS = 24 - 2 - OFFSET_BITS - IDX_BITS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [23:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  cache_state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][LINE_WORDS];

  logic [IDX_BITS-1:0]    fill_idx_q;
  logic [TAG_BITS-1:0]    fill_tag_q;
  logic [OFFSET_BITS-1:0] fill_cnt_q;
  logic                   poison_q;

  logic [IDX_BITS-1:0]    cpu_idx;
  logic [TAG_BITS-1:0]    cpu_tag;
  logic [OFFSET_BITS-1:0] cpu_off;
  logic                   hit;
  logic                   start_fill;
  logic                   fill_done;
  logic                   unused_addr_bits;

  assign cpu_off          = cpu_addr[3:2];
  assign cpu_idx          = cpu_addr[3+IDX_BITS:4];
  assign cpu_tag          = cpu_addr[23:4+IDX_BITS];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign cpu_rdata = data_q[cpu_idx][cpu_off];
  assign busy      = (state_q == FILL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_ready = cpu_valid && hit;
        if (cpu_valid && !hit) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        mem_valid = 1'b1;
        mem_addr  = {fill_tag_q, fill_idx_q, fill_cnt_q, 2'b00};
        if (mem_ready && fill_cnt_q == 2'd3) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill bookkeeping; poison marks a fill that a flush overtook so its line stays invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      fill_cnt_q <= '0;
      poison_q   <= 1'b0;
    end else if (start_fill) begin
      fill_idx_q <= cpu_idx;
      fill_tag_q <= cpu_tag;
      fill_cnt_q <= '0;
      poison_q   <= 1'b0;
    end else if (state_q == FILL) begin
      if (mem_ready) fill_cnt_q <= fill_cnt_q + 2'd1;
      if (flush)     poison_q   <= 1'b1;
    end
  end

  // A flush landing on the completing edge still wins over the new valid bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      if (fill_done) begin
        tag_q[fill_idx_q]   <= fill_tag_q;
        valid_q[fill_idx_q] <= !poison_q;
      end
      if (flush) valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ready) data_q[fill_idx_q][fill_cnt_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_spimemio_cache.sv
// Self-checking bench for spimemio_cache: directed and random reads against a line-address
// model of the cache, with the bench acting as the flash controller.
module tb_spimemio_cache;

  logic        clk;
  logic        resetn;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: which 16-byte line address each of the 16 slots holds.
  bit          m_valid [16];
  logic [19:0] m_line  [16];

  spimemio_cache #(.LINES(16)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return 32'hA0 + ((32'(a) - 32'h10) >> 2);
  endfunction

  function automatic bit model_hit(input logic [23:0] a);
    return m_valid[a[7:4]] && (m_line[a[7:4]] == a[23:4]);
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One CPU read; the bench answers the fill burst with random wait cycles.
  // flush_word >= 0 pulses flush at the start of that fill word; reset_after > 0 resets
  // after that many words; flush_idle pulses flush together with the request cycle.
  task automatic applyStimulus(input logic [23:0] addr, input int maxdly, input int flush_word,
                               input int reset_after, input bit flush_idle);
    logic [23:0] base;
    logic [23:0] ea;
    bit          exp_hit;
    bit          poisoned;
    bit          done;
    int          fw_pending;
    int          d;
    base       = {addr[23:4], 4'h0};
    fw_pending = flush_word;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    flush     = flush_idle;
    #1;
    exp_hit = model_hit(addr);
    checkOutput("req_ready", cpu_ready, exp_hit);
    if (flush_idle) model_flush();
    if (exp_hit) begin
      checkOutput("hit_rdata", cpu_rdata, flash_word({addr[23:2], 2'b00}));
      checkOutput("hit_no_mem", mem_valid, 1'b0);
      @(negedge clk);
      flush     = 1'b0;
      cpu_valid = 1'b0;
      return;
    end
    poisoned = 1'b0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("fill_busy", busy, 1'b1);
      for (int w = 0; w < 4; w++) begin
        ea = base + 24'(w * 4);
        d  = $urandom_range(0, maxdly);
        if (w == fw_pending) begin
          flush      = 1'b1;
          fw_pending = -1;
          poisoned   = 1'b1;
          model_flush();
        end
        for (int i = 0; i < d; i++) begin
          mem_ready = 1'b0;
          #1;
          checkOutput("wait_mem_valid", mem_valid, 1'b1);
          checkOutput("wait_mem_addr", mem_addr, ea);
          checkOutput("wait_cpu_ready", cpu_ready, 1'b0);
          @(negedge clk);
          flush = 1'b0;
        end
        mem_ready = 1'b1;
        mem_rdata = flash_word(ea);
        #1;
        checkOutput("hs_mem_valid", mem_valid, 1'b1);
        checkOutput("hs_mem_addr", mem_addr, ea);
        checkOutput("hs_cpu_ready", cpu_ready, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        flush     = 1'b0;
        if (w + 1 == reset_after) begin
          resetn = 1'b0;
          #1;
          checkOutput("rst_mem_valid", mem_valid, 1'b0);
          checkOutput("rst_busy", busy, 1'b0);
          checkOutput("rst_mem_addr", mem_addr, 24'h0);
          checkOutput("rst_cpu_ready", cpu_ready, 1'b0);
          model_flush();
          @(negedge clk);
          resetn    = 1'b1;
          cpu_valid = 1'b0;
          return;
        end
      end
      #1;
      checkOutput("post_busy", busy, 1'b0);
      checkOutput("post_mem_valid", mem_valid, 1'b0);
      if (poisoned) begin
        checkOutput("poison_ready", cpu_ready, 1'b0);
        poisoned = 1'b0;
      end else begin
        checkOutput("fill_ready", cpu_ready, 1'b1);
        checkOutput("fill_rdata", cpu_rdata, flash_word({addr[23:2], 2'b00}));
        m_valid[addr[7:4]] = 1'b1;
        m_line[addr[7:4]]  = addr[23:4];
        done = 1'b1;
      end
    end
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] ra;
    resetn    = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_flush();
    #3 resetn = 1'b0;
    #1;
    checkOutput("reset_cpu_ready", cpu_ready, 1'b0);
    checkOutput("reset_mem_valid", mem_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 24'h0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] cold miss and hits");
    applyStimulus(24'h000014, 0, -1, 0, 1'b0);
    applyStimulus(24'h000010, 0, -1, 0, 1'b0);
    applyStimulus(24'h000018, 0, -1, 0, 1'b0);
    applyStimulus(24'h00001C, 0, -1, 0, 1'b0);

    $display("[TB] conflict on index 1");
    applyStimulus(24'h000110, 2, -1, 0, 1'b0);
    applyStimulus(24'h000010, 2, -1, 0, 1'b0);

    $display("[TB] random reads with backpressure");
    for (int n = 0; n < 14; n++) begin
      ra = (24'($urandom_range(0, 3)) << 8) | (24'($urandom_range(0, 63)) << 2)
         | 24'($urandom_range(0, 3));
      applyStimulus(ra, 20, -1, 0, 1'b0);
    end

    $display("[TB] flush in idle with simultaneous hit");
    applyStimulus(24'h000010, 3, -1, 0, 1'b0);
    applyStimulus(24'h000010, 3, -1, 0, 1'b1);
    applyStimulus(24'h000010, 3, -1, 0, 1'b0);

    $display("[TB] flush during fill");
    applyStimulus(24'h000020, 3, -1, 0, 1'b0);
    applyStimulus(24'h000034, 3, -1, 0, 1'b0);
    applyStimulus(24'h000048, 3, 1, 0, 1'b0);
    applyStimulus(24'h000020, 3, -1, 0, 1'b0);
    applyStimulus(24'h000034, 3, -1, 0, 1'b0);

    $display("[TB] reset mid-fill");
    applyStimulus(24'h000050, 3, -1, 2, 1'b0);
    applyStimulus(24'h000050, 3, -1, 0, 1'b0);
    applyStimulus(24'h00005C, 0, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
